// File: rtl/pdm_demodulator.sv
// PDM demodulator: synchronises a 1-bit pulse-density stream and recovers its density over DECIM ena strobes.
// Define PDM_DEMOD_SLIDING_EN for a sliding boxcar average instead of block decimation.
module pdm_demodulator #(
   parameter  int DECIM       = 32,
   parameter  int SYNC_STAGES = 2,
   localparam int CW          = $clog2(DECIM + 1)
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          ena,
   input  logic          pdm_in,
   input  logic          restart,
   output logic [CW-1:0] value,
   output logic          valid,
   output logic          active
);

   typedef enum logic {IDLE, ACC} state_t;

   state_t state;
   logic   pdm_s;

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign pdm_s = pdm_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;

         // Runs every cycle regardless of ena so the delay is fixed in clk cycles
         always_ff @(posedge clk) begin
            if (!nrst) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= pdm_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign pdm_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

`ifdef PDM_DEMOD_SLIDING_EN

   logic [DECIM-1:0] shreg;
   logic [CW-1:0]    sum;
   logic [CW-1:0]    fill;
   logic [CW-1:0]    sum_next;

   assign sum_next = sum + CW'(pdm_s) - CW'(shreg[DECIM-1]);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         shreg  <= '0;
         sum    <= '0;
         fill   <= '0;
         value  <= '0;
         valid  <= 1'b0;
         active <= 1'b0;
         state  <= IDLE;
      end else begin
         valid <= 1'b0;
         if (restart) begin
            shreg  <= '0;
            sum    <= '0;
            fill   <= '0;
            active <= 1'b0;
            state  <= IDLE;
         end else if (ena) begin
            shreg  <= {shreg[DECIM-2:0], pdm_s};
            sum    <= sum_next;
            state  <= ACC;
            active <= 1'b1;
            if (fill != CW'(DECIM)) begin
               fill <= fill + 1'b1;
            end
            // Output is only meaningful once the window holds DECIM real samples
            if (fill >= CW'(DECIM - 1)) begin
               value <= sum_next;
               valid <= 1'b1;
            end
         end
      end
   end

`else

   logic [CW-1:0] acc;
   logic [CW-1:0] smp_cnt;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         acc     <= '0;
         smp_cnt <= '0;
         value   <= '0;
         valid   <= 1'b0;
         active  <= 1'b0;
         state   <= IDLE;
      end else begin
         valid <= 1'b0;
         if (restart) begin
            acc     <= '0;
            smp_cnt <= '0;
            active  <= 1'b0;
            state   <= IDLE;
         end else if (ena) begin
            case (state)
               IDLE: begin
                  acc     <= CW'(pdm_s);
                  smp_cnt <= CW'(1);
                  active  <= 1'b1;
                  state   <= ACC;
               end
               default: begin
                  // Windows run back-to-back: the final sample closes one and the next ena opens another
                  if (smp_cnt == CW'(DECIM - 1)) begin
                     value   <= acc + CW'(pdm_s);
                     valid   <= 1'b1;
                     acc     <= '0;
                     smp_cnt <= '0;
                  end else begin
                     acc     <= acc + CW'(pdm_s);
                     smp_cnt <= smp_cnt + 1'b1;
                  end
                  active <= 1'b1;
                  state  <= ACC;
               end
            endcase
         end
      end
   end

`endif

endmodule

// File: tb/tb_pdm_demodulator.sv
// Directed self-checking bench for pdm_demodulator (DECIM=32, SYNC_STAGES=2).
// Exercises the sliding boxcar instead when PDM_DEMOD_SLIDING_EN is defined.
module tb_pdm_demodulator;

   localparam int DECIM = 32;
   localparam int CW    = $clog2(DECIM + 1);

   logic          clk = 1'b0;
   logic          nrst;
   logic          ena;
   logic          pdm_in;
   logic          restart;
   logic [CW-1:0] value;
   logic          valid;
   logic          active;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pdm_demodulator #(.DECIM(DECIM), .SYNC_STAGES(2)) dut (
      .clk    (clk),
      .nrst   (nrst),
      .ena    (ena),
      .pdm_in (pdm_in),
      .restart(restart),
      .value  (value),
      .valid  (valid),
      .active (active)
   );

   // All tasks start and end 1 time unit after a rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_and_restart(input logic bit_val);
      ena     = 1'b0;
      pdm_in  = bit_val;
      restart = 1'b0;
      repeat (3) tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
   endtask

   task automatic test_reset();
      nrst    = 1'b0;
      ena     = 1'b0;
      pdm_in  = 1'b0;
      restart = 1'b0;
      repeat (3) tick();
      checks++; if (value !== '0) begin errors++; $display("[TB] FAIL reset_value got %0d want 0", value); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
      checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active got %b want 0", active); end
   endtask

`ifndef PDM_DEMOD_SLIDING_EN

   task automatic test_all_ones();
      logic          exp_v;
      logic [CW-1:0] exp_val;
      nrst   = 1'b1;
      ena    = 1'b1;
      pdm_in = 1'b1;
      for (int c = 1; c <= 96; c++) begin
         tick();
         if (c == 1) begin
            checks++; if (active !== 1'b1) begin errors++; $display("[TB] FAIL ones_active got %b want 1", active); end
         end
         exp_v = (c % 32 == 0);
         checks++; if (valid !== exp_v) begin errors++; $display("[TB] FAIL ones_valid c=%0d got %b want %b", c, valid, exp_v); end
         if (exp_v) begin
            exp_val = (c == 32) ? CW'(30) : CW'(32);
            checks++; if (value !== exp_val) begin errors++; $display("[TB] FAIL ones_value c=%0d got %0d want %0d", c, value, exp_val); end
         end
      end
      ena = 1'b0;
   endtask

   task automatic test_all_zeros();
      logic exp_v;
      flush_and_restart(1'b0);
      checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL zeros_restart_active got %b want 0", active); end
      checks++; if (value !== CW'(32)) begin errors++; $display("[TB] FAIL zeros_held_value got %0d want 32", value); end
      ena = 1'b1;
      for (int c = 1; c <= 64; c++) begin
         tick();
         if (c == 1) begin
            checks++; if (active !== 1'b1) begin errors++; $display("[TB] FAIL zeros_active got %b want 1", active); end
         end
         if (c == 31) begin
            checks++; if (value !== CW'(32)) begin errors++; $display("[TB] FAIL zeros_hold c=31 got %0d want 32", value); end
         end
         exp_v = (c % 32 == 0);
         checks++; if (valid !== exp_v) begin errors++; $display("[TB] FAIL zeros_valid c=%0d got %b want %b", c, valid, exp_v); end
         if (exp_v) begin
            checks++; if (value !== '0) begin errors++; $display("[TB] FAIL zeros_value c=%0d got %0d want 0", c, value); end
         end
      end
      ena = 1'b0;
   endtask

   task automatic test_toggle();
      logic exp_v;
      ena     = 1'b0;
      restart = 1'b0;
      repeat (4) begin
         pdm_in = ~pdm_in;
         tick();
      end
      restart = 1'b1;
      pdm_in  = ~pdm_in;
      tick();
      restart = 1'b0;
      ena     = 1'b1;
      for (int c = 1; c <= 64; c++) begin
         pdm_in = ~pdm_in;
         tick();
         exp_v = (c % 32 == 0);
         checks++; if (valid !== exp_v) begin errors++; $display("[TB] FAIL toggle_valid c=%0d got %b want %b", c, valid, exp_v); end
         if (exp_v) begin
            checks++; if (value !== CW'(16)) begin errors++; $display("[TB] FAIL toggle_value c=%0d got %0d want 16", c, value); end
         end
      end
      ena = 1'b0;
   endtask

   task automatic test_sparse_ena();
      logic exp_v;
      flush_and_restart(1'b1);
      for (int c = 1; c <= 256; c++) begin
         ena = ((c % 4) == 1);
         tick();
         exp_v = ((c % 128) == 125);
         checks++; if (valid !== exp_v) begin errors++; $display("[TB] FAIL sparse_valid c=%0d got %b want %b", c, valid, exp_v); end
         if (exp_v) begin
            checks++; if (value !== CW'(32)) begin errors++; $display("[TB] FAIL sparse_value c=%0d got %0d want 32", c, value); end
         end
      end
      ena = 1'b0;
   endtask

   task automatic test_restart();
      logic exp_v;
      flush_and_restart(1'b0);
      ena = 1'b1;
      repeat (10) tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL restart_active got %b want 0", active); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL restart_valid got %b want 0", valid); end
      for (int c = 1; c <= 32; c++) begin
         tick();
         exp_v = (c == 32);
         checks++; if (valid !== exp_v) begin errors++; $display("[TB] FAIL restart_window_valid c=%0d got %b want %b", c, valid, exp_v); end
         if (c < 32) begin
            checks++; if (value !== CW'(32)) begin errors++; $display("[TB] FAIL restart_hold c=%0d got %0d want 32", c, value); end
         end else begin
            checks++; if (value !== '0) begin errors++; $display("[TB] FAIL restart_value got %0d want 0", value); end
         end
      end
      pdm_in = 1'b1;
      repeat (31) tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      ena     = 1'b0;
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL restart_at_end_valid got %b want 0", valid); end
      repeat (3) begin
         tick();
         checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL restart_after_valid got %b want 0", valid); end
      end
      checks++; if (value !== '0) begin errors++; $display("[TB] FAIL restart_at_end_value got %0d want 0", value); end
   endtask

   task automatic test_reset_midwindow();
      flush_and_restart(1'b1);
      ena = 1'b1;
      for (int c = 1; c <= 42; c++) begin
         tick();
         if (c == 32) begin
            checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_valid got %b want 1", valid); end
            checks++; if (value !== CW'(32)) begin errors++; $display("[TB] FAIL midrst_pre_value got %0d want 32", value); end
         end
      end
      nrst = 1'b0;
      tick();
      checks++; if (value !== '0) begin errors++; $display("[TB] FAIL midrst_value got %0d want 0", value); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b want 0", valid); end
      checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL midrst_active got %b want 0", active); end
      nrst = 1'b1;
      ena  = 1'b0;
      repeat (5) begin
         tick();
         checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after_valid got %b want 0", valid); end
      end
   endtask

`else

   task automatic test_sliding();
      logic          exp_v;
      logic [CW-1:0] exp_val;
      nrst   = 1'b1;
      ena    = 1'b1;
      pdm_in = 1'b0;
      for (int c = 1; c <= 90; c++) begin
         if (c == 41) pdm_in = 1'b1;
         tick();
         exp_v = (c >= 32);
         if (c < 43) exp_val = '0;
         else if (c - 42 > 32) exp_val = CW'(32);
         else exp_val = CW'(c - 42);
         checks++; if (valid !== exp_v) begin errors++; $display("[TB] FAIL slide_valid c=%0d got %b want %b", c, valid, exp_v); end
         if (exp_v) begin
            checks++; if (value !== exp_val) begin errors++; $display("[TB] FAIL slide_value c=%0d got %0d want %0d", c, value, exp_val); end
         end
      end
      ena = 1'b0;
   endtask

`endif

   initial begin
      nrst    = 1'b0;
      ena     = 1'b0;
      pdm_in  = 1'b0;
      restart = 1'b0;
      tick();
      test_reset();
`ifndef PDM_DEMOD_SLIDING_EN
      test_all_ones();
      test_all_zeros();
      test_toggle();
      test_sparse_ena();
      test_restart();
      test_reset_midwindow();
`else
      test_sliding();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pdm_demodulator.md
Name: pdm_demodulator

Overview:
Receive-side companion to the PDM modulator. Consumes a 1-bit pulse-density stream and recovers the modulation setpoint by counting ones over a decimation window of DECIM sample strobes. The result is a DECIM-scaled density value with a one-cycle valid strobe. Used in loopback benches against the modulator, and for decoding PDM streams from external devices in another clock domain via the built-in input synchroniser.

Parameters:
DECIM, 32, window length in ena strobes; legal range 2..65535.
SYNC_STAGES, 2, synchroniser flops on pdm_in; 0 = bypass (pdm_in already in clk domain).
CW, $clog2(DECIM+1), localparam; width of count/value.

Ports:
clk  in  1  system clock, all logic on posedge
nrst  in  1  synchronous active-low reset
ena  in  1  sample strobe; one PDM bit consumed per cycle with ena=1
pdm_in  in  1  PDM bitstream, may be asynchronous to clk
restart  in  1  synchronous window restart, one-cycle pulse
value  out  CW  ones count of last completed window, 0..DECIM
valid  out  1  one-cycle strobe; value updated this cycle
active  out  1  high while a window is being accumulated

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on nrst.
- Reset (nrst=0 at posedge): sync flops=0, smp_cnt=0, acc=0, value=0, valid=0, active=0, state=IDLE.
- Synchroniser: pdm_s = pdm_in delayed SYNC_STAGES clk cycles. It is clocked every cycle, independent of ena. The sample taken on an ena cycle is the current pdm_s.
- FSM states:
  - IDLE: active=0. First ena moves to ACC and counts that sample: acc<=pdm_s, smp_cnt<=1.
  - ACC: active=1. On each ena, acc<=acc+pdm_s and smp_cnt<=smp_cnt+1.
- Window end: on the ena where smp_cnt==DECIM-1:
  - value<=acc+pdm_s, valid<=1 in the same register update, so valid is visible the cycle after the final ena.
  - acc<=0, smp_cnt<=0; state stays ACC (windows are back-to-back, no gap samples).
- valid is high for exactly one cycle per window. value holds between strobes.
- Width: acc and value are CW bits. acc never exceeds DECIM, so no overflow/saturation logic.
- ena=0: no state change; valid drops after its single cycle.
- restart=1: acc=0, smp_cnt=0, state=IDLE, valid=0. value holds its last result. restart has priority over a simultaneous ena, and that sample is dropped. If restart coincides with a window-end ena, that window is discarded (no valid).
- Reset mid-window: partial window discarded, no valid, value=0.
- Latency: pdm_in to counted sample = SYNC_STAGES cycles. Final ena of a window to valid = 1 cycle.

Optional Feature:
Macro PDM_DEMOD_SLIDING_EN.
- Defined: sliding boxcar instead of decimation.
  - DECIM-bit shift register of samples plus running sum: sum<=sum+new-oldest on each ena.
  - Fill counter suppresses valid until DECIM samples have been collected since reset/restart.
  - After fill, valid pulses one cycle after every ena, value=sum.
  - restart clears the shift register, sum and fill counter; value holds.
- Undefined: decimating behaviour above. No shift register is instantiated.

Test Plan:
1. DECIM=32, SYNC_STAGES=2, pdm_in=1, ena=1 every cycle from reset release -> first valid value=30 (two reset-zero sync samples), all following valid value=32, strobes every 32 cycles.
2. pdm_in=0 constant, ena=1 -> value=0 on every strobe, valid period 32 cycles, active=1 after first ena.
3. pdm_in toggling each clk, ena=1 -> steady-state value=16. Then loopback: pdm_modulator (MOD_WIDTH=5) with setpoint 20 driving pdm_in -> value within ±1 of the expected density on every window.
4. ena asserted every 4th cycle, pdm_in=1 -> valid every 128 cycles, value=32, valid never asserted on a non-window-end cycle.
5. restart after 10 samples of window, same cycle as ena -> that sample dropped, active=0 for one cycle, next valid exactly 32 enas after restart, value unchanged in between. nrst=0 mid-window -> value=0, no valid.
6. PDM_DEMOD_SLIDING_EN defined, DECIM=32, pdm_in=0 for 40 enas then 1 -> no valid during first 32 enas. Afterwards valid on every ena, value stays 0, then ramps 1,2,...,32 once ones reach the sample point, then holds 32.
